// File: rtl/raycast_pkg.sv
// rtl/raycast_pkg.sv - shared ray-stage FSM encodings and dispatcher state type
package raycast_pkg;

   // Ray-stage FSM encoding, shared with the FSM itself so both ends agree.
   typedef enum logic [1:0] {
      FSM_IDLE    = 2'b00,
      FSM_FEED    = 2'b01,
      FSM_PROCESS = 2'b10,
      FSM_DONE    = 2'b11
   } fsm_state_t;

   typedef enum logic [2:0] {
      D_IDLE,
      D_TO_FEED,
      D_WAIT_FEED,
      D_LOAD,
      D_TO_PROC,
      D_WAIT_PROC,
      D_RUN,
      D_WAIT_DONE
   } disp_state_t;

endpackage

// File: rtl/ray_angle_accum.sv
// rtl/ray_angle_accum.sv - load/step angle accumulator, wraps modulo 2^ANGLE_W
module ray_angle_accum #(
   parameter int ANGLE_W = 10,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [ANGLE_W-1:0] load_value,
   output logic [ANGLE_W-1:0] angle
);

   localparam logic [ANGLE_W-1:0] STEP_W = ANGLE_W'(STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         angle <= '0;
      end else if (load) begin
         angle <= load_value;
      end else if (step) begin
         angle <= angle + STEP_W;
      end
   end

endmodule

// File: rtl/ray_dispatcher.sv
// rtl/ray_dispatcher.sv - per-frame sequencer stepping the ray-stage FSM and ray processor
module ray_dispatcher
   import raycast_pkg::*;
#(
   parameter int NUM_RAYS   = 320,
   parameter int IDX_W      = 9,
   parameter int ANGLE_W    = 10,
   parameter int HALF_FOV   = 85,
   parameter int ANGLE_STEP = 1,
   parameter int WAIT_LIMIT = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic [ANGLE_W-1:0] player_angle,
   input  logic [1:0]         fsm_state,
   output logic               switch_state,
   output logic [IDX_W-1:0]   ray_idx,
   output logic [ANGLE_W-1:0] ray_angle,
   output logic               ray_start,
   input  logic               ray_done,
   output logic               frame_done,
   output logic               busy
);

   localparam logic [ANGLE_W-1:0] HALF_FOV_W = ANGLE_W'(HALF_FOV);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_RAYS - 1);
   localparam int                 WC_W       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WC_W-1:0]    WAIT_LAST  = WC_W'(WAIT_LIMIT - 1);

   disp_state_t        state;
   logic [IDX_W-1:0]   cur_idx;
   logic [WC_W-1:0]    wait_cnt;
   logic [ANGLE_W-1:0] acc_angle;
   logic [ANGLE_W-1:0] acc_load_value;
   logic               accept;
   logic               acc_step;

   assign accept         = (state == D_IDLE) && frame_start;
   assign acc_step       = (state == D_WAIT_DONE) && ray_done && (cur_idx != LAST_IDX);
   assign acc_load_value = player_angle - HALF_FOV_W;

   ray_angle_accum #(
      .ANGLE_W (ANGLE_W),
      .STEP    (ANGLE_STEP)
   ) u_accum (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .step       (acc_step),
      .load_value (acc_load_value),
      .angle      (acc_angle)
   );

   // switch_state is registered, so the pulse for a D_TO_* cycle is decided on
   // entry; the FSM only moves on our own pulses, so fsm_state is stable then.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= D_IDLE;
         switch_state <= 1'b0;
         ray_start    <= 1'b0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
         ray_idx      <= '0;
         ray_angle    <= '0;
         cur_idx      <= '0;
         wait_cnt     <= '0;
      end else begin
         switch_state <= 1'b0;
         ray_start    <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            D_IDLE: begin
               if (frame_start) begin
                  cur_idx      <= '0;
                  busy         <= 1'b1;
                  switch_state <= (fsm_state != FSM_FEED);
                  state        <= D_TO_FEED;
               end
            end
            D_TO_FEED: begin
               if (!switch_state && fsm_state == FSM_FEED) begin
                  ray_idx   <= cur_idx;
                  ray_angle <= acc_angle;
                  state     <= D_LOAD;
               end else begin
                  wait_cnt <= '0;
                  state    <= D_WAIT_FEED;
               end
            end
            D_WAIT_FEED: begin
               if (fsm_state == FSM_FEED) begin
                  ray_idx   <= cur_idx;
                  ray_angle <= acc_angle;
                  state     <= D_LOAD;
               end else if (wait_cnt == WAIT_LAST) begin
                  switch_state <= 1'b1;
                  state        <= D_TO_FEED;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            D_LOAD: begin
               switch_state <= (fsm_state != FSM_PROCESS);
               state        <= D_TO_PROC;
            end
            D_TO_PROC: begin
               if (!switch_state && fsm_state == FSM_PROCESS) begin
                  ray_start <= 1'b1;
                  state     <= D_RUN;
               end else begin
                  wait_cnt <= '0;
                  state    <= D_WAIT_PROC;
               end
            end
            D_WAIT_PROC: begin
               // A DONE FSM needs several retries (DONE->IDLE->FEED->PROCESS).
               if (fsm_state == FSM_PROCESS) begin
                  ray_start <= 1'b1;
                  state     <= D_RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  switch_state <= 1'b1;
                  state        <= D_TO_PROC;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            D_RUN: begin
               state <= D_WAIT_DONE;
            end
            D_WAIT_DONE: begin
               if (ray_done) begin
                  if (cur_idx == LAST_IDX) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= D_IDLE;
                  end else begin
                     cur_idx      <= cur_idx + 1'b1;
                     switch_state <= (fsm_state != FSM_FEED);
                     state        <= D_TO_FEED;
                  end
               end
            end
            default: state <= D_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb/tb_ray_dispatcher.sv - scoreboard bench for ray_dispatcher with FSM and processor models
module tb_ray_dispatcher;

   localparam int NUM_RAYS   = 4;
   localparam int IDX_W      = 9;
   localparam int ANGLE_W    = 10;
   localparam int HALF_FOV   = 85;
   localparam int ANGLE_STEP = 1;
   localparam int WAIT_LIMIT = 7;

   typedef struct {
      int cyc;
      int idx;
      int ang;
   } ray_exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               frame_start = 1'b0;
   logic [ANGLE_W-1:0] player_angle = '0;
   logic [1:0]         fsm_state;
   logic               switch_state;
   logic [IDX_W-1:0]   ray_idx;
   logic [ANGLE_W-1:0] ray_angle;
   logic               ray_start;
   logic               ray_done;
   logic               frame_done;
   logic               busy;
   logic               proc_done = 1'b0;
   logic               stray_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int f = 0;

   int       exp_pulse[$];
   ray_exp_t exp_ray[$];
   int       exp_fd[$];

   assign ray_done = proc_done | stray_done;

   ray_dispatcher #(
      .NUM_RAYS   (NUM_RAYS),
      .IDX_W      (IDX_W),
      .ANGLE_W    (ANGLE_W),
      .HALF_FOV   (HALF_FOV),
      .ANGLE_STEP (ANGLE_STEP),
      .WAIT_LIMIT (WAIT_LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_start  (frame_start),
      .player_angle (player_angle),
      .fsm_state    (fsm_state),
      .switch_state (switch_state),
      .ray_idx      (ray_idx),
      .ray_angle    (ray_angle),
      .ray_start    (ray_start),
      .ray_done     (ray_done),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Ray-stage FSM model: edge-detects switch_state; can drop one chosen pulse.
   logic [1:0] fsm_q = 2'b00;
   logic       sw_d = 1'b0;
   int         pulse_count = 0;
   int         ignore_at = -1;
   assign fsm_state = fsm_q;

   always @(posedge clk) begin
      if (reset) begin
         fsm_q <= 2'b00;
         sw_d  <= 1'b0;
      end else begin
         sw_d <= switch_state;
         if (switch_state && !sw_d) begin
            pulse_count <= pulse_count + 1;
            if (pulse_count + 1 != ignore_at)
               fsm_q <= (fsm_q == 2'b00) ? 2'b01 :
                        (fsm_q == 2'b01) ? 2'b10 :
                        (fsm_q == 2'b10) ? 2'b01 : 2'b00;
         end
      end
   end

   // Ray processor model: ray_done three cycles after ray_start.
   int proc_cnt = 0;
   always @(posedge clk) begin
      if (reset) begin
         proc_cnt  <= 0;
         proc_done <= 1'b0;
      end else begin
         proc_done <= 1'b0;
         if (ray_start) begin
            proc_cnt <= 2;
         end else if (proc_cnt == 1) begin
            proc_done <= 1'b1;
            proc_cnt  <= 0;
         end else if (proc_cnt > 1) begin
            proc_cnt <= proc_cnt - 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Schedule relative to frame_start cycle f; off = extra cycles from one ignored feed pulse.
   task automatic push_frame(input int fs, input int ang0, input int off, input bit full);
      exp_pulse.push_back(fs + 1);
      if (off > 0) exp_pulse.push_back(fs + 1 + off);
      exp_pulse.push_back(fs + 4 + off);
      exp_ray.push_back(ray_exp_t'{fs + 6 + off, 0, ang0});
      if (full) begin
         for (int r = 1; r < NUM_RAYS; r++) begin
            exp_pulse.push_back(fs + 9*r + 1 + off);
            exp_pulse.push_back(fs + 9*r + 4 + off);
            exp_ray.push_back(ray_exp_t'{fs + 9*r + 6 + off, r, (ang0 + r) % 1024});
         end
         exp_fd.push_back(fs + 9*NUM_RAYS + 1 + off);
      end
   endtask

   task automatic start_frame(input int ang, input int ang0, input int off, input bit full,
                              output int fs);
      @(posedge clk); #1;
      fs = cyc;
      push_frame(fs, ang0, off, full);
      player_angle = ANGLE_W'(ang);
      frame_start  = 1'b1;
      @(posedge clk); #1;
      frame_start  = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_busy_cleared"}, int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_switch_state"}, int'(switch_state), 0);
      chk({tag, "_ray_start"},    int'(ray_start), 0);
      chk({tag, "_ray_idx"},      int'(ray_idx), 0);
      chk({tag, "_ray_angle"},    int'(ray_angle), 0);
      chk({tag, "_frame_done"},   int'(frame_done), 0);
      chk({tag, "_busy"},         int'(busy), 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT emits a pulse/start/done.
   logic prev_sw = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         prev_sw <= 1'b0;
      end else begin
         prev_sw <= switch_state;
         if (switch_state) begin
            chk("switch_low_gap", int'(prev_sw), 0);
            if (exp_pulse.size() == 0) chk("unexpected_pulse_cycle", cyc, -1);
            else begin
               chk("pulse_cycle", cyc, exp_pulse[0]);
               void'(exp_pulse.pop_front());
            end
         end
         if (ray_start) begin
            if (exp_ray.size() == 0) chk("unexpected_ray_start_cycle", cyc, -1);
            else begin
               chk("ray_start_cycle", cyc, exp_ray[0].cyc);
               chk("ray_idx", int'(ray_idx), exp_ray[0].idx);
               chk("ray_angle", int'(ray_angle), exp_ray[0].ang);
               void'(exp_ray.pop_front());
            end
         end
         if (frame_done) begin
            chk("busy_at_frame_done", int'(busy), 0);
            if (exp_fd.size() == 0) chk("unexpected_frame_done_cycle", cyc, -1);
            else begin
               chk("frame_done_cycle", cyc, exp_fd[0]);
               void'(exp_fd.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Frame 1: FSM in IDLE, angles 15..18.
      start_frame(100, 15, 0, 1'b1, f);
      chk("frame1_busy_cycle1", int'(busy), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("frame1_angle_cycle3", int'(ray_angle), 15);
      chk("frame1_idx_cycle3", int'(ray_idx), 0);
      wait_frame("frame1");

      // ray_done while idle must not move anything.
      chk("idx_before_stray", int'(ray_idx), 3);
      stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idx_after_stray", int'(ray_idx), 3);
      chk("busy_after_stray", int'(busy), 0);

      // Frame 2: FSM left in PROCESS, ray 0 angle wraps to 949; extra frame_start mid-frame.
      start_frame(10, 949, 0, 1'b1, f);
      repeat (19) @(posedge clk);
      #1;
      player_angle = ANGLE_W'(500);
      frame_start  = 1'b1;
      @(posedge clk); #1;
      frame_start  = 1'b0;
      wait_frame("frame2");

      // Frame 3: FSM drops the first feed pulse; re-pulse WAIT_LIMIT+1 cycles later.
      ignore_at = pulse_count + 1;
      start_frame(200, 115, 8, 1'b1, f);
      wait_frame("frame3");

      // Frame 4: reset during D_WAIT_DONE of ray 0.
      start_frame(100, 15, 0, 1'b0, f);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("midframe_reset");

      // Frame 5: fresh frame after reset runs normally.
      start_frame(100, 15, 0, 1'b1, f);
      wait_frame("frame5");

      repeat (5) @(posedge clk);
      #1;
      chk("pending_pulses", exp_pulse.size(), 0);
      chk("pending_ray_starts", exp_ray.size(), 0);
      chk("pending_frame_dones", exp_fd.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
